lmg_result_buffer: RTL and testbench
====================================

# lmg_result_buffer

Avalon-MM slave that sits between the HPS software and the legal move generator (LMG). Software writes a board state into a parametrised register window and sets start. The block then launches the LMG and drains its move stream into an on-chip result RAM. It reports the move count, done, busy and overflow, and holds the results until software acknowledges. It generalises the earlier fixed 16-register/RAM control block with:
- parametrised register window, board size and move width;
- a real sequencing FSM;
- fixed-latency reads.

## Interface
Parameters:
- DATA_WIDTH, 32, Avalon data width and RAM word width.
- ADDR_WIDTH, 15, Avalon word address width; total address space is 2^ADDR_WIDTH words.
- REG_ADDR_BITS, 4, register window size 2^REG_ADDR_BITS words at addresses 0..2^REG_ADDR_BITS-1.
- BOARD_WORDS, 8, board registers at addresses 2..BOARD_WORDS+1. Must satisfy BOARD_WORDS+2 ≤ 2^REG_ADDR_BITS.
- MOVE_WIDTH, 16, LMG move word width. Must satisfy MOVE_WIDTH ≤ DATA_WIDTH.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- slave_address  in  ADDR_WIDTH  word address.
- slave_read  in  1  read request.
- slave_write  in  1  write request.
- slave_writedata  in  DATA_WIDTH  write data.
- slave_byteenable  in  DATA_WIDTH/8  byte enables.
- slave_readdata  out  DATA_WIDTH  read data, valid with slave_readdatavalid.
- slave_readdatavalid  out  1  one-cycle pulse, exactly 1 cycle after each accepted read.
- gen_start  out  1  one-cycle launch pulse to the LMG.
- gen_board  out  BOARD_WORDS*DATA_WIDTH  board registers concatenated, reg 2 in the LSBs.
- gen_move  in  MOVE_WIDTH  move word from the LMG.
- gen_valid  in  1  gen_move is valid.
- gen_last  in  1  qualifies the final move of the list; valid only with gen_valid.
- gen_ready  out  1  block accepts a move this cycle.

## Operation
Address map (RESULT_BASE = 2^REG_ADDR_BITS, CAP = 2^ADDR_WIDTH − RESULT_BASE):
- Reg 0, CTRL:
  - bit0 start, RW.
  - bit1 done, RO.
  - bit2 clear, write-1, self-clearing, reads 0.
  - bit3 busy, RO.
  - bit4 overflow, RO.
  - Other bits read 0.
- Reg 1, COUNT: RO, number of moves stored.
- Regs 2..BOARD_WORDS+1: board state, RW, per-byte byteenable honoured.
- Other register words: RW scratch, byteenable honoured.
- RESULT_BASE..2^ADDR_WIDTH−1: result RAM.
  - Readable at all times.
  - Software writes are accepted only when busy=0 and all byteenables are set; otherwise the write is silently dropped.
- Writes to RO bits and RO registers are ignored.

FSM states: IDLE, LAUNCH, COLLECT, DONE.
- IDLE
  - busy=0, done=0.
  - A write that changes start from 0 to 1 (with clear=0 in the same write) zeroes COUNT and overflow, then moves to LAUNCH.
- LAUNCH
  - gen_start=1 for this cycle only; busy=1.
  - Next state is COLLECT.
- COLLECT
  - gen_ready=1, busy=1.
  - Each cycle with gen_valid & gen_ready, while COUNT < CAP: write {zero-extend, gen_move} to RAM[RESULT_BASE+COUNT], then COUNT+1.
  - If COUNT = CAP: the move is discarded, overflow=1, and COUNT saturates.
  - An accepted beat with gen_last (that beat still stored if room) moves to DONE.
- DONE
  - done=1, busy=0, gen_ready=0.
  - COUNT, overflow and RAM are held.
  - A write with start=0 returns to IDLE and clears done.
- Board registers are write-protected while busy=1; writes are ignored, so gen_board is stable throughout a run.
- clear=1 from any state:
  - next state IDLE;
  - COUNT=0, overflow=0, start=0, done=0;
  - RAM contents are unchanged.
  - If clear and start are written together, clear wins.
- gen_valid outside COLLECT is ignored.
- Reset mid-run aborts immediately. The LMG must tolerate gen_ready dropping.

## Timing
- Reset values:
  - slave_readdata=0, slave_readdatavalid=0;
  - gen_start=0, gen_ready=0, gen_board=0;
  - all registers 0; state IDLE.
- Reads have fixed 1-cycle latency for both registers and RAM. Back-to-back reads are sustained at 1 per cycle.
- Register read-after-write: the next-cycle read returns the new value.
- Start written at cycle T:
  - LAUNCH and gen_start at T+1;
  - COLLECT and gen_ready from T+2.
- Beat accepted at cycle k: the RAM write and COUNT update occur at the end of k.
- gen_last accepted at L: DONE at L+1. A CTRL read issued at L+1 returns done=1 and the final COUNT at L+2.
- Throughput: 1 move per cycle in COLLECT.

## Test plan
- Reset, then read CTRL, COUNT and reg 2 → all 0; readdatavalid pulses exactly 1 cycle after each read.
- Write board regs 0x11111111..0x88888888, then set start → one gen_start pulse at T+1, gen_board matching the writes, and busy=1.
- LMG streams 20 moves (0x0001..0x0014) with valid gaps, last on beat 20 → done=1, COUNT=20, and RAM[RESULT_BASE..+19] holds 0x00000001..0x00000014.
- With ADDR_WIDTH=5, REG_ADDR_BITS=4 (CAP=16), stream 18 moves → COUNT=16, overflow=1, RAM holds only the first 16 moves.
- During COLLECT, write board reg 2 = 0xDEADBEEF and then clear → the board is unchanged, state returns to IDLE with COUNT=0, and gen_ready drops the next cycle.
- Assert reset asynchronously mid-COLLECT → gen_ready=0 immediately and CTRL reads 0; a subsequent start runs normally.

Source files
------------

// File: rtl/lmg_result_buffer.sv
// lmg_result_buffer: Avalon-MM register window plus result RAM that sequences
// one legal-move-generator run and captures its move stream for software.
module lmg_result_buffer #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDR_WIDTH    = 15,
    parameter int unsigned REG_ADDR_BITS = 4,
    parameter int unsigned BOARD_WORDS   = 8,
    parameter int unsigned MOVE_WIDTH    = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [ADDR_WIDTH-1:0]         slave_address,
    input  logic                          slave_read,
    input  logic                          slave_write,
    input  logic [DATA_WIDTH-1:0]         slave_writedata,
    input  logic [DATA_WIDTH/8-1:0]       slave_byteenable,
    output logic [DATA_WIDTH-1:0]         slave_readdata,
    output logic                          slave_readdatavalid,
    output logic                          gen_start,
    output logic [BOARD_WORDS*DATA_WIDTH-1:0] gen_board,
    input  logic [MOVE_WIDTH-1:0]         gen_move,
    input  logic                          gen_valid,
    input  logic                          gen_last,
    output logic                          gen_ready
);

    localparam int unsigned BE_WIDTH    = DATA_WIDTH / 8;
    localparam int unsigned REG_WORDS   = 2 ** REG_ADDR_BITS;
    localparam int unsigned RESULT_BASE = REG_WORDS;
    localparam int unsigned CAP         = (2 ** ADDR_WIDTH) - RESULT_BASE;
    localparam int unsigned BOARD_LO    = 2;
    localparam int unsigned BOARD_HI    = BOARD_WORDS + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_COLLECT,
        S_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic                    start_q, start_d;
    logic                    ovf_q, ovf_d;
    logic [ADDR_WIDTH-1:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0]   regs_q [REG_WORDS];
    logic [DATA_WIDTH-1:0]   regs_d [REG_WORDS];
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    rvalid_q, rvalid_d;
    logic                    gen_start_q, gen_start_d;
    logic                    gen_ready_q, gen_ready_d;

    logic [DATA_WIDTH-1:0]   ram [CAP];
    logic                    ram_we;
    logic [ADDR_WIDTH-1:0]   ram_waddr;
    logic [DATA_WIDTH-1:0]   ram_wdata;

    logic                    is_reg;
    logic [REG_ADDR_BITS-1:0] reg_idx;
    logic [ADDR_WIDTH-1:0]   ram_idx;
    logic                    busy;
    logic                    done;
    logic                    is_board;
    logic                    ctrl_wr;
    logic                    wr_start;
    logic                    wr_clear;
    logic                    beat;

    // Byte-lane merge of a write into an existing word.
    function automatic logic [DATA_WIDTH-1:0] merge_be(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [BE_WIDTH-1:0]   be
    );
        logic [DATA_WIDTH-1:0] r;
        r = old_w;
        for (int b = 0; b < int'(BE_WIDTH); b++) begin
            if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return r;
    endfunction

    // Address decode and handshake qualifiers.
    always_comb begin
        is_reg   = (slave_address < ADDR_WIDTH'(RESULT_BASE));
        reg_idx  = slave_address[REG_ADDR_BITS-1:0];
        ram_idx  = slave_address - ADDR_WIDTH'(RESULT_BASE);
        busy     = (state_q == S_LAUNCH) || (state_q == S_COLLECT);
        done     = (state_q == S_DONE);
        is_board = (32'(reg_idx) >= BOARD_LO) && (32'(reg_idx) <= BOARD_HI);
        ctrl_wr  = slave_write && is_reg && (reg_idx == REG_ADDR_BITS'(0)) && slave_byteenable[0];
        wr_start = ctrl_wr && slave_writedata[0];
        wr_clear = ctrl_wr && slave_writedata[2];
        beat     = gen_ready_q && gen_valid;
    end

    // Sequencer, register file updates and RAM write arbitration.
    always_comb begin
        state_d   = state_q;
        start_d   = start_q;
        ovf_d     = ovf_q;
        count_d   = count_q;
        regs_d    = regs_q;
        ram_we    = 1'b0;
        ram_waddr = ram_idx;
        ram_wdata = slave_writedata;

        if (slave_write && is_reg) begin
            if (reg_idx == REG_ADDR_BITS'(0)) begin
                if (slave_byteenable[0]) start_d = slave_writedata[0];
            end else if (reg_idx != REG_ADDR_BITS'(1)) begin
                if (!(busy && is_board)) begin
                    regs_d[reg_idx] = merge_be(regs_q[reg_idx], slave_writedata, slave_byteenable);
                end
            end
        end

        // Software RAM writes only when idle-side and full-word.
        if (slave_write && !is_reg && !busy && (&slave_byteenable)) begin
            ram_we = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (wr_start && !start_q) begin
                    count_d = '0;
                    ovf_d   = 1'b0;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_d = S_COLLECT;
            end
            S_COLLECT: begin
                if (beat && !wr_clear) begin
                    if (count_q < ADDR_WIDTH'(CAP)) begin
                        ram_we    = 1'b1;
                        ram_waddr = count_q;
                        ram_wdata = DATA_WIDTH'(gen_move);
                        count_d   = count_q + ADDR_WIDTH'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (gen_last) state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (ctrl_wr && !slave_writedata[0]) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Clear overrides everything, including a simultaneous start.
        if (wr_clear) begin
            state_d = S_IDLE;
            count_d = '0;
            ovf_d   = 1'b0;
            start_d = 1'b0;
        end

        gen_start_d = (state_d == S_LAUNCH);
        gen_ready_d = (state_d == S_COLLECT);
    end

    // Fixed one-cycle read path for registers and RAM.
    always_comb begin
        rvalid_d = slave_read;
        rdata_d  = rdata_q;
        if (slave_read) begin
            if (is_reg) begin
                if (reg_idx == REG_ADDR_BITS'(0)) begin
                    rdata_d = DATA_WIDTH'({ovf_q, busy, 1'b0, done, start_q});
                end else if (reg_idx == REG_ADDR_BITS'(1)) begin
                    rdata_d = DATA_WIDTH'(count_q);
                end else begin
                    rdata_d = regs_q[reg_idx];
                end
            end else begin
                rdata_d = ram[ram_idx];
            end
        end
    end

    // State and control registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            start_q     <= 1'b0;
            ovf_q       <= 1'b0;
            count_q     <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            gen_start_q <= 1'b0;
            gen_ready_q <= 1'b0;
            for (int i = 0; i < int'(REG_WORDS); i++) regs_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            ovf_q       <= ovf_d;
            count_q     <= count_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
            gen_start_q <= gen_start_d;
            gen_ready_q <= gen_ready_d;
            regs_q      <= regs_d;
        end
    end

    // Result RAM: contents survive clear and reset.
    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_waddr] <= ram_wdata;
    end

    // Output wiring from registered state.
    always_comb begin
        slave_readdata      = rdata_q;
        slave_readdatavalid = rvalid_q;
        gen_start           = gen_start_q;
        gen_ready           = gen_ready_q;
        for (int w = 0; w < int'(BOARD_WORDS); w++) begin
            gen_board[w*DATA_WIDTH +: DATA_WIDTH] = regs_q[w + 2];
        end
    end

endmodule

// File: tb/tb_lmg_result_buffer.sv
// tb_lmg_result_buffer: randomized scenarios against a transaction-level model.
module tb_lmg_result_buffer;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 6;
    localparam int unsigned RAB   = 4;
    localparam int unsigned BW    = 8;
    localparam int unsigned MW    = 16;
    localparam int unsigned REGW  = 16;
    localparam int unsigned RBASE = 16;
    localparam int unsigned CAP   = 48;

    logic              clk = 1'b0;
    logic              reset;
    logic [AW-1:0]     slave_address;
    logic              slave_read;
    logic              slave_write;
    logic [DW-1:0]     slave_writedata;
    logic [DW/8-1:0]   slave_byteenable;
    logic [DW-1:0]     slave_readdata;
    logic              slave_readdatavalid;
    logic              gen_start;
    logic [BW*DW-1:0]  gen_board;
    logic [MW-1:0]     gen_move;
    logic              gen_valid;
    logic              gen_last;
    logic              gen_ready;

    lmg_result_buffer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_ADDR_BITS(RAB),
        .BOARD_WORDS(BW), .MOVE_WIDTH(MW)
    ) dut (
        .clk(clk), .reset(reset),
        .slave_address(slave_address), .slave_read(slave_read),
        .slave_write(slave_write), .slave_writedata(slave_writedata),
        .slave_byteenable(slave_byteenable), .slave_readdata(slave_readdata),
        .slave_readdatavalid(slave_readdatavalid), .gen_start(gen_start),
        .gen_board(gen_board), .gen_move(gen_move), .gen_valid(gen_valid),
        .gen_last(gen_last), .gen_ready(gen_ready)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Reference model state
    logic [DW-1:0] m_reg [REGW];
    logic [DW-1:0] m_ram [CAP];
    int            m_count;
    bit            m_ovf, m_start, m_done, m_busy;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] m_ctrl();
        return DW'((int'(m_ovf) << 4) | (int'(m_busy) << 3) | (int'(m_done) << 1) | int'(m_start));
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < int'(REGW); i++) m_reg[i] = '0;
        m_count = 0; m_ovf = 0; m_start = 0; m_done = 0; m_busy = 0;
    endfunction

    // Model effect of a write to a board/scratch register or the RAM
    function automatic void m_data_write(input int addr, input logic [DW-1:0] d, input logic [3:0] be);
        if (addr >= int'(RBASE)) begin
            if (!m_busy && be == 4'hF) m_ram[addr - int'(RBASE)] = d;
        end else if (addr >= 2) begin
            if (!(m_busy && addr <= int'(BW) + 1)) begin
                for (int b = 0; b < 4; b++) if (be[b]) m_reg[addr][b*8 +: 8] = d[b*8 +: 8];
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic bus_write(input int addr, input logic [DW-1:0] d, input logic [3:0] be);
        slave_address = AW'(addr); slave_writedata = d; slave_byteenable = be; slave_write = 1'b1;
        tick();
        slave_write = 1'b0;
    endtask

    task automatic bus_read(input int addr, output logic [DW-1:0] d);
        slave_address = AW'(addr); slave_read = 1'b1;
        tick();
        slave_read = 1'b0;
        chk("rvalid", 64'(slave_readdatavalid), 64'd1);
        d = slave_readdata;
    endtask

    task automatic read_chk(input string tag, input int addr, input logic [DW-1:0] exp);
        logic [DW-1:0] d;
        bus_read(addr, d);
        chk(tag, 64'(d), 64'(exp));
    endtask

    task automatic ram_burst(input int n);
        for (int i = 0; i < n; i++) begin
            slave_address = AW'(int'(RBASE) + i); slave_read = 1'b1;
            tick();
            chk("ram_rvalid", 64'(slave_readdatavalid), 64'd1);
            chk("ram_word", 64'(slave_readdata), 64'(m_ram[i]));
        end
        slave_read = 1'b0;
    endtask

    task automatic board_chk();
        for (int w = 0; w < int'(BW); w++) chk("gen_board", 64'(gen_board[w*DW +: DW]), 64'(m_reg[w + 2]));
    endtask

    // Start a run; gen_valid is held high during LAUNCH to show it is ignored there.
    task automatic start_run();
        bus_write(0, 32'h1, 4'hF);
        m_start = 1; m_busy = 1; m_done = 0; m_count = 0; m_ovf = 0;
        chk("gen_start_pulse", 64'(gen_start), 64'd1);
        chk("ready_in_launch", 64'(gen_ready), 64'd0);
        gen_valid = 1'b1; gen_move = 16'hBAD0; gen_last = 1'b1;
        tick();
        gen_valid = 1'b0; gen_last = 1'b0;
        chk("gen_start_drop", 64'(gen_start), 64'd0);
        chk("ready_in_collect", 64'(gen_ready), 64'd1);
    endtask

    // Stream n moves with random valid gaps; seq_base!=0 gives seq_base+i, else random
    task automatic stream(input int n, input bit with_last, input int seq_base);
        int idx = 0;
        int cyc = 0;
        bit v, acc;
        logic [MW-1:0] mv;
        while (idx < n && cyc < 2000) begin
            v  = ($urandom_range(0, 3) != 0);
            mv = (seq_base != 0) ? MW'(seq_base + idx) : MW'($urandom);
            gen_valid = v; gen_move = mv; gen_last = v && with_last && (idx == n - 1);
            acc = v && gen_ready;
            tick();
            if (acc) begin
                if (m_count < int'(CAP)) begin
                    m_ram[m_count] = DW'(mv);
                    m_count++;
                end else begin
                    m_ovf = 1;
                end
                if (with_last && idx == n - 1) begin m_done = 1; m_busy = 0; end
                idx++;
            end
            cyc++;
        end
        gen_valid = 1'b0; gen_last = 1'b0;
        chk("stream_beats", 64'(idx), 64'(n));
    endtask

    task automatic finish_run_chk();
        chk("ready_after_last", 64'(gen_ready), 64'd0);
        read_chk("ctrl_done", 0, m_ctrl());
        read_chk("count_done", 1, DW'(m_count));
        ram_burst(m_count);
    endtask

    initial begin
        logic [DW-1:0] d;
        reset = 1'b1; slave_address = '0; slave_read = 0; slave_write = 0;
        slave_writedata = '0; slave_byteenable = '0;
        gen_move = '0; gen_valid = 0; gen_last = 0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_readdata", 64'(slave_readdata), 64'd0);
        chk("rst_rvalid", 64'(slave_readdatavalid), 64'd0);
        chk("rst_gen_start", 64'(gen_start), 64'd0);
        chk("rst_gen_ready", 64'(gen_ready), 64'd0);
        board_chk();
        reset = 1'b0;
        tick();

        // Reset values and readdatavalid pulse width
        read_chk("rst_ctrl", 0, m_ctrl());
        tick();
        chk("rvalid_pulse_end", 64'(slave_readdatavalid), 64'd0);
        read_chk("rst_count", 1, 32'd0);
        read_chk("rst_reg2", 2, 32'd0);

        // Board load, partial byte enables, scratch register
        for (int i = 0; i < int'(BW); i++) begin
            bus_write(2 + i, 32'h11111111 * (i + 1), 4'hF);
            m_data_write(2 + i, 32'h11111111 * (i + 1), 4'hF);
        end
        d = $urandom;
        bus_write(9, d, 4'b1010); m_data_write(9, d, 4'b1010);
        read_chk("board_partial_be", 9, m_reg[9]);
        d = $urandom;
        bus_write(12, d, 4'b0101); m_data_write(12, d, 4'b0101);
        read_chk("scratch", 12, m_reg[12]);
        board_chk();

        // Software RAM writes while idle: full word kept, partial dropped
        d = $urandom; bus_write(int'(RBASE) + 30, d, 4'hF); m_data_write(int'(RBASE) + 30, d, 4'hF);
        d = $urandom; bus_write(int'(RBASE) + 30, d, 4'b0111); m_data_write(int'(RBASE) + 30, d, 4'b0111);
        read_chk("ram_sw_write", int'(RBASE) + 30, m_ram[30]);

        // Normal 20-move run
        start_run();
        read_chk("ctrl_busy", 0, m_ctrl());
        d = $urandom; bus_write(int'(RBASE) + 30, d, 4'hF); m_data_write(int'(RBASE) + 30, d, 4'hF);
        stream(20, 1, 1);
        finish_run_chk();
        read_chk("ram_busy_drop", int'(RBASE) + 30, m_ram[30]);
        board_chk();
        bus_write(0, 32'h0, 4'hF); m_start = 0; m_done = 0;
        read_chk("ctrl_back_idle", 0, m_ctrl());

        // Overflow run: 50 moves into a 48-entry RAM
        start_run();
        stream(50, 1, 0);
        finish_run_chk();
        bus_write(0, 32'h0, 4'hF); m_start = 0; m_done = 0;
        read_chk("ctrl_ovf_held", 0, m_ctrl());
        read_chk("count_held", 1, DW'(m_count));

        // Board protection during COLLECT, then clear
        start_run();
        stream(3, 0, 0);
        bus_write(2, 32'hDEADBEEF, 4'hF); m_data_write(2, 32'hDEADBEEF, 4'hF);
        board_chk();
        bus_write(0, 32'h4, 4'hF);
        m_start = 0; m_busy = 0; m_done = 0; m_count = 0; m_ovf = 0;
        chk("ready_after_clear", 64'(gen_ready), 64'd0);
        read_chk("ctrl_cleared", 0, m_ctrl());
        read_chk("count_cleared", 1, 32'd0);
        ram_burst(3);
        read_chk("reg2_protected", 2, m_reg[2]);

        // Clear and start in one write: clear wins
        bus_write(0, 32'h5, 4'hF);
        chk("no_start_on_clear", 64'(gen_start), 64'd0);
        read_chk("ctrl_clear_wins", 0, m_ctrl());

        // Random register traffic while idle
        for (int k = 0; k < 10; k++) begin
            int a;
            logic [3:0] be;
            a = $urandom_range(2, int'(REGW) - 1);
            d = $urandom; be = 4'($urandom);
            bus_write(a, d, be); m_data_write(a, d, be);
            read_chk("reg_rand", a, m_reg[a]);
        end

        // Asynchronous reset mid-COLLECT, then a fresh run
        start_run();
        stream(4, 0, 0);
        #2 reset = 1'b1;
        #1;
        chk("ready_async_reset", 64'(gen_ready), 64'd0);
        for (int i = 0; i < int'(REGW); i++) m_reg[i] = '0;
        m_count = 0; m_ovf = 0; m_start = 0; m_done = 0; m_busy = 0;
        board_chk();
        @(posedge clk); #1;
        reset = 1'b0;
        tick();
        read_chk("ctrl_after_reset", 0, m_ctrl());
        read_chk("count_after_reset", 1, 32'd0);
        read_chk("reg2_after_reset", 2, 32'd0);
        for (int i = 0; i < int'(BW); i++) begin
            d = $urandom;
            bus_write(2 + i, d, 4'hF); m_data_write(2 + i, d, 4'hF);
        end
        start_run();
        board_chk();
        stream(7, 1, 0);
        finish_run_chk();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
